// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Pipeline-stage register with valid/ready handshakes on both sides and a
//   2-entry skid buffer, so in_ready is a flop output and never depends
//   combinationally on out_ready. Includes a synchronous flush (branch or
//   hazard squash) and a saturating stall-cycle counter for performance
//   monitoring.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream payload valid (registered)
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  downstream payload (registered)
//   flush      in   1      synchronous squash of all held entries
//   clr_cnt    in   1      synchronous clear of stall_cnt
//   stall_cnt  out  CNTW   saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter int               CNTW   = 16,
  parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNTW-1:0]  stall_cnt
);

  // Occupancy encoding: bit 0 is the main-valid flag, bit 1 the skid-valid
  // flag, so the handshake outputs come straight off state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

  logic acc;
  logic snd;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  assign acc = in_valid & in_ready;
  assign snd = out_valid & out_ready;

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= RSTVAL;
      skid_data_q <= RSTVAL;
      stall_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next occupancy and data-register loads; flush overrides any transfer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // A word accepted this cycle is dropped; a word sent this cycle has
      // already been taken by the downstream stage.
      state_d     = EMPTY;
      main_data_d = RSTVAL;
      skid_data_d = RSTVAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_data_d = in_data;
            state_d     = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (acc && snd) begin
            main_data_d = in_data;
            state_d     = ONE;
          end else if (acc) begin
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (snd) begin
            // main_data keeps the departed word; only the valid flag drops.
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          // in_ready is low here, so no new word can arrive.
          if (snd) begin
            main_data_d = skid_data_q;
            state_d     = ONE;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          // Unreachable encoding (skid valid without main valid): recover.
          state_d     = EMPTY;
          main_data_d = RSTVAL;
          skid_data_d = RSTVAL;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment, flush is ignored.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = CNT_ZERO;
    end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int          WIDTH  = 32;
  localparam int          CNTW   = 4;
  localparam logic [31:0] RSTVAL = 32'hC0DE_0001;
  localparam int          CMAX   = 15;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic             clr_cnt;
  logic [CNTW-1:0]  stall_cnt;

  pipe_stage_reg #(.WIDTH(WIDTH), .CNTW(CNTW), .RSTVAL(RSTVAL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of held words (at most two), value left on the
  // output register when empty, and an integer stall count.
  logic [31:0] q[$];
  logic [31:0] hold_val;
  int          m_cnt;

  int n_total;
  int n_pass;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold_val = RSTVAL;
    m_cnt    = 0;
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("in_ready",  {31'd0, in_ready},  (q.size() < 2) ? 32'd1 : 32'd0);
    chk("out_data",  out_data, (q.size() > 0) ? q[0] : hold_val);
    chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic c);
    int  occ;
    bit  m_acc;
    bit  m_snd;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    clr_cnt   = c;
    @(posedge clk);
    occ   = q.size();
    m_acc = v && (occ < 2);
    m_snd = r && (occ > 0);
    if (c) m_cnt = 0;
    else if ((occ > 0) && !r && (m_cnt < CMAX)) m_cnt++;
    if (m_snd) hold_val = q.pop_front();
    if (f) begin
      q.delete();
      hold_val = RSTVAL;
    end else if (m_acc) begin
      q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    flush = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("rst_data", out_data, RSTVAL);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Streaming at full rate.
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    chk("stream0", out_data, 32'h11);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    chk("stream1", out_data, 32'h22);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    chk("stream2", out_data, 32'h33);
    chk("stream_rdy", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stream_hold", out_data, 32'h33);

    // Backpressure fills the skid buffer, then drains in order.
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_full_data", out_data, 32'hA1);
    // Toggling out_ready between edges must not move in_ready.
    out_ready = 1'b1;
    #1;
    chk("bp_no_comb", {31'd0, in_ready}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_drain0", out_data, 32'hA2);
    chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_drain1", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a word presented upstream.
    step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b1, 1'b1, 1'b0);
    chk("flush_v", {31'd0, out_valid}, 32'd0);
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    chk("flush_data", out_data, RSTVAL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_gone", {31'd0, out_valid}, 32'd0);
    // Flush in ONE with a simultaneous accept: the accepted word is dropped.
    step(1'b1, 32'hC4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC5, 1'b0, 1'b1, 1'b0);
    chk("flush_acc", {31'd0, out_valid}, 32'd0);

    // Stall counter saturation and clear.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("stall_flush", {28'd0, stall_cnt}, 32'd15);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("stall_clr", {28'd0, stall_cnt}, 32'd0);

    // Asynchronous reset mid-stream, between edges.
    step(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hE2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_v", {31'd0, out_valid}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready}, 32'd1);
    chk("arst_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("arst_data", out_data, RSTVAL);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Randomised traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
